// File: rtl/keypad_pkg.sv
// Shared keypad types and constants for the matrix driver and the downstream value decoder.
// Column contents: col 0 = [1,4,7,*], col 1 = [2,5,8,0], col 2 = [3,6,9,#]; rows 0..3 top to bottom.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_e;

  localparam int NUM_COLS = 3;
  localparam int NUM_ROWS = 4;

  // Row/column code reported for an ambiguous multi-key press; the decoder maps it to 4'b1111.
  localparam logic [1:0] KEY_ERR = 2'b11;

  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] v);
    first_low = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!v[i]) first_low = 2'(i);
    end
  endfunction

  function automatic logic multi_low(input logic [NUM_ROWS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!v[i]) n++;
    end
    multi_low = (n > 1);
  endfunction

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] idx);
    col_strobe = ~(3'b001 << idx);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs, presets to all-ones (idle level of pulled-up lines).
// Latency 2 clk; no flow control.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_driver.sv
// 3x4 keypad scanner/debouncer: strobes columns, debounces rows, pulses key_valid once per press; no backpressure.
// Press latency 2 clk sync + wait for column + (DEBOUNCE_CNT-1)*SCAN_DIV + 1 clk. Option: KEYPAD_MULTI_ERR_EN.
module keypad_matrix_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_sense,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [1:0]          key_row,
  output logic [1:0]          key_col,
  output logic                key_valid,
  output logic                key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

  logic [NUM_ROWS-1:0] rs;

  keypad_sync #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_sense),
    .q_o   (rs)
  );

  state_e              state_q;
  logic [DW-1:0]       dwell_q;
  logic [1:0]          col_idx_q;
  logic [NUM_COLS-1:0] col_drive_q;
  logic [1:0]          cap_row_q;
  logic [1:0]          cap_col_q;
  logic [CW-1:0]       deb_cnt_q;
  logic [CW-1:0]       rel_cnt_q;
  logic                pend_q;
  logic [1:0]          key_row_q;
  logic [1:0]          key_col_q;
  logic                key_valid_q;
  logic                key_held_q;

  logic          sample_hit;
  logic          any_low;
  logic [1:0]    win_row;
  logic [1:0]    col_nxt;
  logic [CW-1:0] deb_inc;
  logic [CW-1:0] rel_inc;
  logic          press_match;
  logic [1:0]    acc_row;
  logic [1:0]    acc_col;

  assign sample_hit = (dwell_q == DWELL_LAST);
  assign any_low    = ~&rs;
  assign win_row    = first_low(rs);
  assign col_nxt    = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
  assign deb_inc    = (deb_cnt_q == CNT_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;
  assign rel_inc    = (rel_cnt_q == CNT_MAX) ? rel_cnt_q : rel_cnt_q + 1'b1;

`ifdef KEYPAD_MULTI_ERR_EN
  logic                err_q;
  logic [NUM_ROWS-1:0] cap_pat_q;

  // An ambiguous capture must repeat bit-for-bit; a single key only needs the same winning row.
  assign press_match = err_q ? (rs == cap_pat_q) : (any_low && (win_row == cap_row_q));
  assign acc_row     = err_q ? KEY_ERR : cap_row_q;
  assign acc_col     = err_q ? KEY_ERR : cap_col_q;
`else
  assign press_match = any_low && (win_row == cap_row_q);
  assign acc_row     = cap_row_q;
  assign acc_col     = cap_col_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= sample_hit ? '0 : dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      col_drive_q <= 3'b110;
      cap_row_q   <= 2'd0;
      cap_col_q   <= 2'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      pend_q      <= 1'b0;
      key_row_q   <= 2'd0;
      key_col_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_MULTI_ERR_EN
      err_q       <= 1'b0;
      cap_pat_q   <= '1;
`endif
    end else begin
      key_valid_q <= 1'b0;
      // Outputs load one clock after acceptance; never coincides with a sample since SCAN_DIV >= 2.
      if (pend_q) begin
        pend_q      <= 1'b0;
        key_valid_q <= 1'b1;
        key_held_q  <= 1'b1;
        key_row_q   <= acc_row;
        key_col_q   <= acc_col;
      end
      case (state_q)
        SCAN: begin
          if (sample_hit) begin
            if (!any_low) begin
              col_idx_q   <= col_nxt;
              col_drive_q <= col_strobe(col_nxt);
            end else begin
              cap_row_q <= win_row;
              cap_col_q <= col_idx_q;
              deb_cnt_q <= CW'(1);
`ifdef KEYPAD_MULTI_ERR_EN
              err_q     <= multi_low(rs);
              cap_pat_q <= rs;
`endif
              if (DEBOUNCE_CNT == 1) begin
                state_q <= PRESSED;
                pend_q  <= 1'b1;
              end else begin
                state_q <= DEBOUNCE;
              end
            end
          end
        end
        DEBOUNCE: begin
          if (sample_hit) begin
            if (press_match) begin
              deb_cnt_q <= deb_inc;
              if (deb_inc == CNT_MAX) begin
                state_q <= PRESSED;
                pend_q  <= 1'b1;
              end
            end else begin
              deb_cnt_q   <= '0;
              state_q     <= SCAN;
              col_idx_q   <= col_nxt;
              col_drive_q <= col_strobe(col_nxt);
            end
          end
        end
        PRESSED: begin
          if (sample_hit) begin
            if (rs[cap_row_q]) begin
              if (rel_inc == CNT_MAX) begin
                rel_cnt_q   <= '0;
                key_held_q  <= 1'b0;
                state_q     <= SCAN;
                col_idx_q   <= col_nxt;
                col_drive_q <= col_strobe(col_nxt);
              end else begin
                rel_cnt_q <= rel_inc;
              end
            end else begin
              rel_cnt_q <= '0;
            end
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_drive = col_drive_q;
  assign key_row   = key_row_q;
  assign key_col   = key_col_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_driver.sv
// Directed bench for keypad_matrix_driver with SCAN_DIV=4, DEBOUNCE_CNT=3 and a simple keypad model.
module tb_keypad_matrix_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_sense;
  logic [2:0] col_drive;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       key_valid;
  logic       key_held;

  logic [2:0] keys [4];

  int n_checks;
  int n_fail;
  int vcount;

  typedef struct {
    int         r;
    int         c;
    logic [1:0] exp_row;
    logic [1:0] exp_col;
    logic [2:0] exp_cd;
    logic [2:0] exp_next_cd;
  } vec_t;

  vec_t vecs [4];

  keypad_matrix_driver #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_sense (row_sense),
    .col_drive (col_drive),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r pulled low while its pressed key's column is strobed.
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_sense[r] = ~|(keys[r] & ~col_drive);
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cd(input logic [2:0] cd, input int budget, output bit ok);
    logic [2:0] prev;
    ok   = 1'b0;
    prev = col_drive;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (col_drive === cd && prev !== cd) begin
        ok = 1'b1;
        break;
      end
      prev = col_drive;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int v0;
    logic [2:0] cd_seq [3];

    n_checks = 0;
    n_fail   = 0;
    vcount   = 0;
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
    cd_seq[0] = 3'b110;
    cd_seq[1] = 3'b101;
    cd_seq[2] = 3'b011;

    //            r  c  row    col    frozen  next col
    vecs[0] = '{1, 1, 2'b01, 2'b01, 3'b101, 3'b011};  // '5'
    vecs[1] = '{0, 0, 2'b00, 2'b00, 3'b110, 3'b101};  // '1'
    vecs[2] = '{3, 2, 2'b11, 2'b10, 3'b011, 3'b110};  // '#'
    vecs[3] = '{3, 1, 2'b11, 2'b01, 3'b101, 3'b011};  // '0'

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_col_drive", 32'(col_drive), 32'h6);
    check("rst_key_row", 32'(key_row), 32'h0);
    check("rst_key_col", 32'(key_col), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);

    // Scan sequence after release: each column strobed for 4 clocks.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("scan_seq_%0d", k), 32'(col_drive), 32'(cd_seq[(k / 4) % 3]));
      @(negedge clk);
    end
    check("scan_no_valid", 32'(vcount), 32'h0);

    for (int i = 0; i < 4; i++) begin
      v0 = vcount;
      keys[vecs[i].r][vecs[i].c] = 1'b1;
      wait_valid(60, ok);
      check($sformatf("v%0d_press_seen", i), 32'(ok), 32'h1);
      check($sformatf("v%0d_key_row", i), 32'(key_row), 32'(vecs[i].exp_row));
      check($sformatf("v%0d_key_col", i), 32'(key_col), 32'(vecs[i].exp_col));
      check($sformatf("v%0d_held", i), 32'(key_held), 32'h1);
      repeat (12) @(negedge clk);
      check($sformatf("v%0d_still_held", i), 32'(key_held), 32'h1);
      check($sformatf("v%0d_col_frozen", i), 32'(col_drive), 32'(vecs[i].exp_cd));
      check($sformatf("v%0d_one_pulse", i), 32'(vcount - v0), 32'h1);
      keys[vecs[i].r][vecs[i].c] = 1'b0;
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_held_min", i), 32'(key_held), 32'h1);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_released", i), 32'(key_held), 32'h0);
      check($sformatf("v%0d_col_next", i), 32'(col_drive), 32'(vecs[i].exp_next_cd));
      check($sformatf("v%0d_row_kept", i), 32'(key_row), 32'(vecs[i].exp_row));
      check($sformatf("v%0d_col_kept", i), 32'(key_col), 32'(vecs[i].exp_col));
      check($sformatf("v%0d_no_repeat", i), 32'(vcount - v0), 32'h1);
    end

    // Bounce: '9' seen at two samples only, then released before the third.
    wait_cd(3'b110, 40, ok);
    check("bounce_sync0", 32'(ok), 32'h1);
    keys[2][2] = 1'b1;
    wait_cd(3'b011, 40, ok);
    check("bounce_sync2", 32'(ok), 32'h1);
    v0 = vcount;
    repeat (8) @(negedge clk);
    keys[2][2] = 1'b0;
    repeat (3) @(negedge clk);
    check("bounce_col_frozen", 32'(col_drive), 32'h3);
    @(negedge clk);
    check("bounce_resume", 32'(col_drive), 32'h6);
    check("bounce_not_held", 32'(key_held), 32'h0);
    repeat (4) @(negedge clk);
    check("bounce_no_valid", 32'(vcount - v0), 32'h0);
    check("bounce_row_kept", 32'(key_row), 32'h3);

    // Reset asserted mid-debounce of '8', then a clean press of '8'.
    wait_cd(3'b110, 40, ok);
    check("rstdeb_sync0", 32'(ok), 32'h1);
    keys[2][1] = 1'b1;
    wait_cd(3'b101, 40, ok);
    check("rstdeb_sync1", 32'(ok), 32'h1);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstdeb_col_drive", 32'(col_drive), 32'h6);
    check("rstdeb_key_row", 32'(key_row), 32'h0);
    check("rstdeb_key_col", 32'(key_col), 32'h0);
    check("rstdeb_valid", 32'(key_valid), 32'h0);
    check("rstdeb_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    wait_valid(60, ok);
    check("rstdeb_press_seen", 32'(ok), 32'h1);
    check("rstdeb_new_row", 32'(key_row), 32'h2);
    check("rstdeb_new_col", 32'(key_col), 32'h1);
    check("rstdeb_new_held", 32'(key_held), 32'h1);
    @(negedge clk);
    check("rstdeb_one_pulse", 32'(vcount - v0), 32'h1);
    keys[2][1] = 1'b0;
    repeat (14) @(negedge clk);
    check("rstdeb_released", 32'(key_held), 32'h0);

    // '3' and '9' together in column 2.
    wait_cd(3'b110, 40, ok);
    check("multi_sync0", 32'(ok), 32'h1);
    keys[0][2] = 1'b1;
    keys[2][2] = 1'b1;
    wait_valid(60, ok);
    check("multi_press_seen", 32'(ok), 32'h1);
`ifdef KEYPAD_MULTI_ERR_EN
    check("multi_key_row", 32'(key_row), 32'h3);
    check("multi_key_col", 32'(key_col), 32'h3);
`else
    check("multi_key_row", 32'(key_row), 32'h0);
    check("multi_key_col", 32'(key_col), 32'h2);
`endif
    check("multi_held", 32'(key_held), 32'h1);
    keys[0][2] = 1'b0;
    keys[2][2] = 1'b0;
    repeat (14) @(negedge clk);
    check("multi_released", 32'(key_held), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
